// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath with register file, ALU, memory
// and priority bus arbitration, sequenced cycle-by-cycle from outside.
module cpu_datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        ZHighout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        Cout,
  input  logic        InPortout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        AND,
  input  logic        GRA,
  input  logic        GRB,
  input  logic        GRC,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic [4:0]  operation,
  input  logic [15:0] Register_enable_Signals,
  output logic [31:0] encoder_input,
  output logic        CON_in
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [31:0] r [16];
  logic [31:0] mem [512];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo, bus;
  logic [63:0] z, alu;

  logic [3:0]  sel;
  logic [15:0] dec, r_en, r_req;
  logic [31:0] c_ext;
  logic [4:0]  op, amt;
  logic        muldiv;

  assign sel = (GRA ? ir[26:23] : 4'd0)
             | (GRB ? ir[22:19] : 4'd0)
             | (GRC ? ir[18:15] : 4'd0);
  assign dec   = 16'd1 << sel;
  assign r_en  = (dec & {16{Rin}}) | Register_enable_Signals;
  assign r_req = dec & {16{Rout | BAout}};
  assign c_ext = {{13{ir[18]}}, ir[18:0]};

  assign encoder_input = {8'd0, Cout, InPortout, MDRout, PCout,
                          Zlowout, ZHighout, LOout, HIout, r_req};

  logic [31:0] src [24];

  always_comb begin
    for (int i = 0; i < 16; i++) src[i] = r[i];
    // Base-address use of R0 reads as constant zero
    if (BAout && sel == 4'd0) src[0] = '0;
    src[16] = hi;
    src[17] = lo;
    src[18] = z[63:32];
    src[19] = z[31:0];
    src[20] = pc;
    src[21] = mdr;
    src[22] = '0;
    src[23] = c_ext;
  end

  always_comb begin
    bus = '0;
    for (int i = 23; i >= 0; i--)
      if (encoder_input[i]) bus = src[i];
  end

  assign op     = AND ? OP_AND : operation;
  assign amt    = bus[4:0];
  assign muldiv = (op == OP_MUL) || (op == OP_DIV);

  logic [63:0] dbl, rol_t, prod;
  logic [31:0] ror_v, shra_v, quo, rem;

  assign dbl    = {y, y};
  assign rol_t  = dbl << amt;
  assign ror_v  = 32'(dbl >> amt);
  assign shra_v = $signed(y) >>> amt;
  assign prod   = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
  assign quo    = $signed(y) / $signed(bus);
  assign rem    = $signed(y) % $signed(bus);

  always_comb begin
    alu = {32'd0, bus};
    case (op)
      OP_ADD:  alu = {32'd0, y + bus};
      OP_SUB:  alu = {32'd0, y - bus};
      OP_AND:  alu = {32'd0, y & bus};
      OP_OR:   alu = {32'd0, y | bus};
      OP_ROR:  alu = {32'd0, ror_v};
      OP_ROL:  alu = {32'd0, rol_t[63:32]};
      OP_SHR:  alu = {32'd0, y >> amt};
      OP_SHRA: alu = {32'd0, shra_v};
      OP_SHL:  alu = {32'd0, y << amt};
      OP_MUL:  alu = prod;
      OP_DIV:  alu = (bus == '0) ? {y, 32'hFFFF_FFFF} : {rem, quo};
      OP_NEG:  alu = {32'd0, -bus};
      OP_NOT:  alu = {32'd0, ~bus};
      default: ;
    endcase
  end

  always_comb begin
    CON_in = 1'b0;
    case (ir[20:19])
      2'b00: CON_in = (bus == '0);
      2'b01: CON_in = (bus != '0);
      2'b10: CON_in = ~bus[31];
      2'b11: CON_in = bus[31];
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (r_en[i]) r[i] <= bus;
      if (Yin)   y   <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (PCin)  pc  <= IncPC ? pc + 32'd1 : bus;
      if (MDRin) mdr <= Read ? mem[mar[8:0]] : bus;
      if (Zin)   z   <= alu;
      if (Zin && muldiv) begin
        hi <= alu[63:32];
        lo <= alu[31:0];
      end
    end
  end

  // Memory survives Clear
  always_ff @(posedge Clock) begin
    if (Write) mem[mar[8:0]] <= mdr;
  end

  logic unused_bits;
  assign unused_bits = ^{ir[31:27], mar[31:9]};

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed sequences, an ALU vector table and random
// ALU vectors against an arithmetic reference model.
module tb_cpu_datapath;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic Clock = 1'b0;
  logic Clear = 1'b1;
  logic PCout, Zlowout, MDRout, ZHighout, LOout, HIout, Cout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, AND;
  logic GRA, GRB, GRC, Rin, Rout, BAout;
  logic [4:0]  operation;
  logic [15:0] Register_enable_Signals;
  logic [31:0] encoder_input;
  logic        CON_in;

  int errors = 0;
  int checks = 0;

  cpu_datapath dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout),
    .Cout(Cout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Write(Write), .AND(AND),
    .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .operation(operation),
    .Register_enable_Signals(Register_enable_Signals),
    .encoder_input(encoder_input),
    .CON_in(CON_in)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  op;
    logic        and_f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic idle();
    PCout = 0; Zlowout = 0; MDRout = 0; ZHighout = 0;
    LOout = 0; HIout = 0; Cout = 0; InPortout = 0;
    MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
    IncPC = 0; Read = 0; Write = 0; AND = 0;
    GRA = 0; GRB = 0; GRC = 0; Rin = 0; Rout = 0; BAout = 0;
    operation = '0;
    Register_enable_Signals = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural ALU: {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(logic [4:0] op, logic [31:0] a,
                                        logic [31:0] b);
    int n;
    longint sa, sb, q, rm;
    logic [63:0] t;
    n  = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD:  return {32'd0, a + b};
      OP_SUB:  return {32'd0, a - b};
      OP_AND:  return {32'd0, a & b};
      OP_OR:   return {32'd0, a | b};
      OP_ROR: begin t = {a, a} >> n; return {32'd0, t[31:0]}; end
      OP_ROL: begin t = {a, a} << n; return {32'd0, t[63:32]}; end
      OP_SHR:  return {32'd0, a >> n};
      OP_SHRA: begin t = 64'(sa >>> n); return {32'd0, t[31:0]}; end
      OP_SHL:  return {32'd0, a << n};
      OP_MUL:  return 64'(sa * sb);
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      OP_NEG:  return {32'd0, 32'd0 - b};
      OP_NOT:  return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  // Leaves Y = v and Z = {0, v}; HI = 1 is used as the constant one
  task automatic build(input logic [31:0] v);
    InPortout = 1; Zin = 1; operation = OP_NOT; tick();
    Zlowout = 1; Zin = 1; operation = OP_NEG; tick();
    Zlowout = 1; Yin = 1; tick();
    InPortout = 1; Zin = 1; operation = OP_DIV; tick();
    InPortout = 1; Yin = 1; tick();
    for (int i = 31; i >= 0; i--) begin
      HIout = 1; Zin = 1; operation = OP_SHL; tick();
      Zlowout = 1; Yin = 1; tick();
      if (v[i]) begin
        HIout = 1; Zin = 1; operation = OP_OR; tick();
        Zlowout = 1; Yin = 1; tick();
      end
    end
  endtask

  task automatic load_ir(input logic [31:0] v);
    build(v);
    Zlowout = 1; IRin = 1; tick();
  endtask

  task automatic run_vec(input vec_t t, input string name);
    logic [4:0] eff;
    build(t.a);
    Zlowout = 1; MDRin = 1; tick();
    build(t.b);
    MDRout = 1; Yin = 1; tick();
    Zlowout = 1; Zin = 1; operation = t.op; AND = t.and_f; tick();
    eff = t.and_f ? OP_AND : t.op;
    check({name, "_z"}, dut.z, t.exp);
    if (eff == OP_MUL || eff == OP_DIV) begin
      check({name, "_hi"}, {32'd0, dut.hi}, {32'd0, t.exp[63:32]});
      check({name, "_lo"}, {32'd0, dut.lo}, {32'd0, t.exp[31:0]});
    end else begin
      check({name, "_hi_kept"}, {32'd0, dut.hi}, 64'd1);
    end
  endtask

  function automatic logic [31:0] r_or(input int skip);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++)
      if (i != skip) acc |= dut.r[i];
    return acc;
  endfunction

  initial begin
    vec_t v;
    logic [4:0] rop;
    logic [31:0] ra, rb;

    tbl.push_back('{OP_ADD,  1'b0, 32'd5, 32'd7, 64'h0000_000C});
    tbl.push_back('{OP_SUB,  1'b0, 32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE});
    tbl.push_back('{OP_AND,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
                    64'h0000_0000_F000_F000});
    tbl.push_back('{OP_OR,   1'b0, 32'h0F0F_0000, 32'h0000_00FF,
                    64'h0000_0000_0F0F_00FF});
    tbl.push_back('{OP_ROR,  1'b0, 32'd1, 32'd1, 64'h0000_0000_8000_0000});
    tbl.push_back('{OP_ROR,  1'b0, 32'h1234_5678, 32'd32,
                    64'h0000_0000_1234_5678});
    tbl.push_back('{OP_ROL,  1'b0, 32'h8000_0000, 32'd1, 64'h1});
    tbl.push_back('{OP_SHR,  1'b0, 32'h8000_0000, 32'd4,
                    64'h0000_0000_0800_0000});
    tbl.push_back('{OP_SHRA, 1'b0, 32'h8000_0000, 32'd4,
                    64'h0000_0000_F800_0000});
    tbl.push_back('{OP_SHL,  1'b0, 32'd3, 32'd31, 64'h0000_0000_8000_0000});
    tbl.push_back('{OP_MUL,  1'b0, 32'hFFFF_FFFE, 32'd3,
                    64'hFFFF_FFFF_FFFF_FFFA});
    tbl.push_back('{OP_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2,
                    64'hFFFF_FFFF_FFFF_FFFD});
    tbl.push_back('{OP_DIV,  1'b0, 32'h55, 32'd0, 64'h0000_0055_FFFF_FFFF});
    tbl.push_back('{OP_NEG,  1'b0, 32'd0, 32'd1, 64'h0000_0000_FFFF_FFFF});
    tbl.push_back('{OP_NOT,  1'b0, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFFF});
    tbl.push_back('{5'b00000, 1'b0, 32'd9, 32'hABCD, 64'h0000_ABCD});
    tbl.push_back('{5'b11111, 1'b0, 32'd5, 32'h1234, 64'h0000_1234});
    tbl.push_back('{OP_ADD,  1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00,
                    64'h0000_0000_F000_F000});

    idle();
    repeat (2) @(posedge Clock);
    #1;
    Clear = 0;

    // Fill state, then assert Clear mid-cycle with loads enabled
    build(32'hDEAD_BEEF);
    Zlowout = 1; MDRin = 1; Yin = 1; PCin = 1; MARin = 1; IRin = 1;
    Register_enable_Signals = '1;
    tick();
    check("preload_pc", {32'd0, dut.pc}, 64'hDEAD_BEEF);
    check("preload_r7", {32'd0, dut.r[7]}, 64'hDEAD_BEEF);
    MARin = 1; Yin = 1; PCin = 1; IncPC = 1; MDRin = 1; IRin = 1;
    Zin = 1; Rin = 1; Register_enable_Signals = '1;
    #2;
    Clear = 1;
    #1;
    check("clr_pc", {32'd0, dut.pc}, 64'd0);
    check("clr_ir", {32'd0, dut.ir}, 64'd0);
    check("clr_mar", {32'd0, dut.mar}, 64'd0);
    check("clr_mdr", {32'd0, dut.mdr}, 64'd0);
    check("clr_y", {32'd0, dut.y}, 64'd0);
    check("clr_z", dut.z, 64'd0);
    check("clr_hilo", {dut.hi, dut.lo}, 64'd0);
    check("clr_regs", {32'd0, r_or(-1)}, 64'd0);
    check("clr_bus", {32'd0, dut.bus}, 64'd0);
    check("clr_enc", {32'd0, encoder_input}, 64'd0);
    @(posedge Clock);
    #1;
    check("clr_hold_pc", {32'd0, dut.pc}, 64'd0);
    Clear = 0;
    idle();

    // Instruction fetch from mem[0]
    build(32'h8880_0000);
    Zlowout = 1; MDRin = 1; tick();
    Write = 1; tick();
    InPortout = 1; MDRin = 1; tick();
    PCout = 1; MARin = 1; tick();
    PCin = 1; IncPC = 1; Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
    check("fetch_mar", {32'd0, dut.mar}, 64'd0);
    check("fetch_pc", {32'd0, dut.pc}, 64'd1);
    check("fetch_ir", {32'd0, dut.ir}, 64'h8880_0000);

    // Read and Write on the same edge
    build(32'h0BAD_F00D);
    Zlowout = 1; MDRin = 1; tick();
    Read = 1; Write = 1; MDRin = 1; tick();
    check("rw_old", {32'd0, dut.mdr}, 64'h8880_0000);
    Read = 1; MDRin = 1; tick();
    check("rw_new", {32'd0, dut.mdr}, 64'h0BAD_F00D);

    // mfhi into R4
    load_ir(32'h0200_0000);
    build(32'h1234_5678);
    InPortout = 1; Zin = 1; operation = OP_DIV; tick();
    check("mfhi_hi", {32'd0, dut.hi}, 64'h1234_5678);
    GRA = 1; Rin = 1; HIout = 1; tick();
    check("mfhi_r4", {32'd0, dut.r[4]}, 64'h1234_5678);
    check("mfhi_others", {32'd0, r_or(4)}, 64'd0);

    // R1 = R2 + R3
    build(32'd5);
    Zlowout = 1; Register_enable_Signals = 16'h0004; tick();
    build(32'd7);
    Zlowout = 1; Register_enable_Signals = 16'h0008; tick();
    load_ir(32'h0091_8000);
    GRB = 1; Rout = 1; Yin = 1; tick();
    GRC = 1; Rout = 1; Zin = 1; operation = OP_ADD;
    #1;
    check("add_enc", {32'd0, encoder_input}, 64'h8);
    check("add_bus", {32'd0, dut.bus}, 64'd7);
    tick();
    Zlowout = 1; GRA = 1; Rin = 1; tick();
    check("add_r1", {32'd0, dut.r[1]}, 64'd12);
    check("add_r2", {32'd0, dut.r[2]}, 64'd5);

    // Branch conditions
    load_ir(32'h0018_0000);
    build(32'h8000_0000);
    Zlowout = 1; #1;
    check("con_neg", {63'd0, CON_in}, 64'd1);
    idle();
    load_ir(32'h0010_0000);
    build(32'h8000_0000);
    Zlowout = 1; #1;
    check("con_pos_fail", {63'd0, CON_in}, 64'd0);
    idle();
    load_ir(32'h0000_0000);
    InPortout = 1; #1;
    check("con_zero", {63'd0, CON_in}, 64'd1);
    idle();
    load_ir(32'h0008_0000);
    InPortout = 1; #1;
    check("con_nonzero", {63'd0, CON_in}, 64'd0);
    idle();

    // Sign-extended constant and bus priority
    load_ir(32'h0004_0000);
    Cout = 1; #1;
    check("c_ext", {32'd0, dut.bus}, 64'hFFFC_0000);
    check("c_enc", {32'd0, encoder_input}, 64'h0080_0000);
    HIout = 1; MDRout = 1; #1;
    check("prio_bus", {32'd0, dut.bus}, 64'd1);
    check("prio_enc", {32'd0, encoder_input}, 64'h00A1_0000);
    idle();

    // R0 versus base-address zero
    build(32'h55);
    Zlowout = 1; Register_enable_Signals = 16'h0001; tick();
    Rout = 1; #1;
    check("r0_rout", {32'd0, dut.bus}, 64'h55);
    Rout = 0; BAout = 1; #1;
    check("r0_baout", {32'd0, dut.bus}, 64'd0);
    check("r0_ba_enc", {32'd0, encoder_input}, 64'd1);
    idle();

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 24; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (rop == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)
        rb = 32'd1;
      v = '{rop, 1'b0, ra, rb, model(rop, ra, rb)};
      run_vec(v, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
